// File: rtl/st7735_pkg.sv
// ST7735 command codes and the decoder state type used by the SPI receive path.
package st7735_pkg;

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    RASET,
    RAMWR,
    SKIP
  } dec_state_t;

  // Every command byte picks the state that interprets the data bytes after it.
  function automatic dec_state_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_CASET: return CASET;
      CMD_RASET: return RASET;
      CMD_RAMWR: return RAMWR;
      CMD_NOP:   return IDLE;
      default:   return SKIP;
    endcase
  endfunction

endpackage

// File: rtl/spi_bit_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
module spi_bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= {STAGES{RST_VAL}};
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/st7735_spi_rx.sv
// ST7735 SPI write-side receiver: oversamples the SPI pins on mco and decodes
// commands, RASET start row and RAMWR RGB565 pixels into one-cycle strobes.
module st7735_spi_rx
  import st7735_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ROW     = 271
) (
  input  logic        mco,
  input  logic        rst,
  input  logic        i_spi_clk,
  input  logic        i_spi_cs,
  input  logic        i_spi_mosi,
  input  logic        i_dc,
  output logic [7:0]  o_inst_data,
  output logic        o_inst_en_pls,
  output logic [15:0] o_pixel_data,
  output logic        o_pixel_en_pls,
  output logic [15:0] o_row_addr,
  output logic        o_row_addr_en_pls
);

  localparam logic [15:0] MAX_ROW_W = 16'(MAX_ROW);

  logic sck_s, cs_s, mosi_s, dc_s;

  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(mco), .rst(rst), .d(i_spi_clk), .q(sck_s));
  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(mco), .rst(rst), .d(i_spi_cs), .q(cs_s));
  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(mco), .rst(rst), .d(i_spi_mosi), .q(mosi_s));
  spi_bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
    .clk(mco), .rst(rst), .d(i_dc), .q(dc_s));

  // Byte assembly; shreg holds the finished byte while byte_vld is high.
  logic       sck_d, byte_vld, byte_dc;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sck_rise;

  assign sck_rise = sck_s & ~sck_d;

  always_ff @(posedge mco) begin
    if (rst) begin
      sck_d    <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      byte_vld <= 1'b0;
      byte_dc  <= 1'b0;
    end else begin
      sck_d    <= sck_s;
      byte_vld <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        shreg   <= {shreg[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_dc  <= dc_s;
        end
      end
    end
  end

  // Decoder: state register plus registered outputs.
  dec_state_t  state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [7:0]  hold, hold_nx;
  logic [7:0]  inst_nx;
  logic [15:0] pix_nx, row_nx, row_val;
  logic        inst_en_nx, pix_en_nx, row_en_nx;

  assign row_val = {hold, shreg};

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    hold_nx    = hold;
    inst_nx    = o_inst_data;
    pix_nx     = o_pixel_data;
    row_nx     = o_row_addr;
    inst_en_nx = 1'b0;
    pix_en_nx  = 1'b0;
    row_en_nx  = 1'b0;
    if (byte_vld) begin
      if (!byte_dc) begin
        inst_nx    = shreg;
        inst_en_nx = 1'b1;
        state_nx   = decode_cmd(shreg);
        idx_nx     = 2'd0;
      end else begin
        case (state)
          CASET: begin
            idx_nx = idx + 2'd1;
            if (idx == 2'd3) state_nx = SKIP;
          end
          RASET: begin
            if (idx == 2'd0) hold_nx = shreg;
            if (idx == 2'd1) begin
              row_nx    = (row_val > MAX_ROW_W) ? MAX_ROW_W : row_val;
              row_en_nx = 1'b1;
            end
            idx_nx = idx + 2'd1;
            if (idx == 2'd3) state_nx = SKIP;
          end
          RAMWR: begin
            if (!idx[0]) begin
              hold_nx = shreg;
              idx_nx  = 2'd1;
            end else begin
              pix_nx    = {hold, shreg};
              pix_en_nx = 1'b1;
              idx_nx    = 2'd0;
            end
          end
          default: ;
        endcase
      end
    end else if (cs_s && state == RAMWR) begin
      idx_nx = 2'd0;  // frame ended: forget a held pixel high byte
    end
  end

  always_ff @(posedge mco) begin
    if (rst) begin
      state             <= IDLE;
      idx               <= 2'd0;
      hold              <= 8'd0;
      o_inst_data       <= 8'd0;
      o_inst_en_pls     <= 1'b0;
      o_pixel_data      <= 16'd0;
      o_pixel_en_pls    <= 1'b0;
      o_row_addr        <= 16'd0;
      o_row_addr_en_pls <= 1'b0;
    end else begin
      state             <= state_nx;
      idx               <= idx_nx;
      hold              <= hold_nx;
      o_inst_data       <= inst_nx;
      o_inst_en_pls     <= inst_en_nx;
      o_pixel_data      <= pix_nx;
      o_pixel_en_pls    <= pix_en_nx;
      o_row_addr        <= row_nx;
      o_row_addr_en_pls <= row_en_nx;
    end
  end

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Bench for st7735_spi_rx: directed table, hand-written corner sequences and
// random frames checked against a byte-level reference model.
module tb_st7735_spi_rx;

  localparam int SS   = 2;
  localparam int MAXR = 271;

  logic        mco = 1'b0, rst = 1'b1;
  logic        sck = 1'b0, cs = 1'b1, mosi = 1'b0, dc = 1'b0;
  logic [7:0]  o_inst_data;
  logic        o_inst_en_pls, o_pixel_en_pls, o_row_addr_en_pls;
  logic [15:0] o_pixel_data, o_row_addr;

  st7735_spi_rx #(.SYNC_STAGES(SS), .MAX_ROW(MAXR)) dut (
    .mco(mco), .rst(rst), .i_spi_clk(sck), .i_spi_cs(cs), .i_spi_mosi(mosi),
    .i_dc(dc), .o_inst_data(o_inst_data), .o_inst_en_pls(o_inst_en_pls),
    .o_pixel_data(o_pixel_data), .o_pixel_en_pls(o_pixel_en_pls),
    .o_row_addr(o_row_addr), .o_row_addr_en_pls(o_row_addr_en_pls));

  always #5 mco = ~mco;

  int cyc = 0;
  always @(posedge mco) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int last_rise = 0, strobe_cyc = -1;
  logic [15:0] obs_inst[$], obs_pix[$], obs_row[$];
  logic [15:0] exp_inst[$], exp_pix[$], exp_row[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int nstb;
  always @(negedge mco) begin
    if (!rst) begin
      nstb = int'(o_inst_en_pls) + int'(o_pixel_en_pls) + int'(o_row_addr_en_pls);
      if (nstb > 0) begin
        chk("one_strobe", nstb, 1);
        strobe_cyc = cyc;
      end
      if (o_inst_en_pls)     obs_inst.push_back({8'h00, o_inst_data});
      if (o_pixel_en_pls)    obs_pix.push_back(o_pixel_data);
      if (o_row_addr_en_pls) obs_row.push_back(o_row_addr);
    end
  end

  // Reference model: what the panel should report for each byte it receives.
  int         m_mode = 0;  // 0 ignore data, 1 row address, 2 pixels
  int         m_cnt = 0;
  logic [7:0] m_first = 8'h00;

  task automatic m_cmd(input logic [7:0] b);
    exp_inst.push_back({8'h00, b});
    m_mode = (b == 8'h2B) ? 1 : (b == 8'h2C) ? 2 : 0;
    m_cnt  = 0;
  endtask

  task automatic m_data(input logic [7:0] b);
    int v;
    if (m_mode == 1) begin
      if (m_cnt == 0) m_first = b;
      if (m_cnt == 1) begin
        v = m_first * 256 + b;
        exp_row.push_back(16'((v > MAXR) ? MAXR : v));
      end
      m_cnt++;
    end else if (m_mode == 2) begin
      if (m_cnt % 2 == 1) exp_pix.push_back({m_first, b});
      else                m_first = b;
      m_cnt++;
    end
  endtask

  task automatic m_cs_high();
    if (m_mode == 2) m_cnt = 0;
  endtask

  // SPI driver: mode 0, each SCK phase lasts 3 mco cycles.
  task automatic tick(input int n);
    repeat (n) @(posedge mco);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic d);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      dc   = d;
      tick(3);
      sck = 1'b1;
      last_rise = cyc;
      tick(3);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    tick(4);
    cs = 1'b1;
    tick(6);
    m_cs_high();
  endtask

  task automatic cmd(input logic [7:0] b);
    send_bits(b, 8, 1'b0);
    m_cmd(b);
  endtask

  task automatic dat(input logic [7:0] b);
    send_bits(b, 8, 1'b1);
    m_data(b);
  endtask

  task automatic compare_all(input string tag);
    tick(10);
    chk({tag, "_n_inst"}, obs_inst.size(), exp_inst.size());
    chk({tag, "_n_pix"},  obs_pix.size(),  exp_pix.size());
    chk({tag, "_n_row"},  obs_row.size(),  exp_row.size());
    for (int i = 0; i < obs_inst.size() && i < exp_inst.size(); i++)
      chk({tag, "_inst"}, obs_inst[i], exp_inst[i]);
    for (int i = 0; i < obs_pix.size() && i < exp_pix.size(); i++)
      chk({tag, "_pix"}, obs_pix[i], exp_pix[i]);
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++)
      chk({tag, "_row"}, obs_row[i], exp_row[i]);
    obs_inst.delete(); obs_pix.delete(); obs_row.delete();
    exp_inst.delete(); exp_pix.delete(); exp_row.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_inst_data"}, o_inst_data, 0);
    chk({tag, "_pix_data"},  o_pixel_data, 0);
    chk({tag, "_row_addr"},  o_row_addr, 0);
    chk({tag, "_strobes"},   {o_inst_en_pls, o_pixel_en_pls, o_row_addr_en_pls}, 0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [7:0]  d[4];
    int          n_pix;
    int          n_row;
    logic [15:0] last;  // last pixel, else last row, else the command byte
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h29, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 16'h0029};
    vecs[1] = '{8'h2C, 4, '{8'hF8, 8'h00, 8'h07, 8'hE0}, 2, 0, 16'h07E0};
    vecs[2] = '{8'h2B, 4, '{8'h00, 8'h0A, 8'h01, 8'h0F}, 0, 1, 16'h000A};
    vecs[3] = '{8'h2B, 2, '{8'h01, 8'h2C, 8'h00, 8'h00}, 0, 1, 16'h010F};
    vecs[4] = '{8'h2A, 4, '{8'h00, 8'h00, 8'h00, 8'h7F}, 0, 0, 16'h002A};
    vecs[5] = '{8'h00, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 0, 0, 16'h0000};
    vecs[6] = '{8'h2C, 3, '{8'hAA, 8'hBB, 8'hCC, 8'h00}, 1, 0, 16'hAABB};

    rst = 1'b1;
    tick(5);
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick(4);

    foreach (vecs[v]) begin
      cs_low();
      cmd(vecs[v].cmd);
      for (int j = 0; j < vecs[v].n; j++) dat(vecs[v].d[j]);
      cs_high();
      tick(10);
      chk("vec_n_inst", obs_inst.size(), 1);
      chk("vec_n_pix", obs_pix.size(), vecs[v].n_pix);
      chk("vec_n_row", obs_row.size(), vecs[v].n_row);
      if (vecs[v].n_pix > 0)      chk("vec_last_pix", obs_pix[$], vecs[v].last);
      else if (vecs[v].n_row > 0) chk("vec_last_row", obs_row[$], vecs[v].last);
      else                        chk("vec_last_inst", obs_inst[$], vecs[v].last);
      compare_all("vec_model");
    end

    // Strobe latency from the 8th SCK rising edge.
    strobe_cyc = -1;
    cs_low();
    cmd(8'h29);
    tick(8);
    chk("latency", strobe_cyc - last_rise, SS + 2);
    cs_high();
    compare_all("latency");

    // Half pixel dropped across a CS deassertion.
    cs_low(); cmd(8'h2C); dat(8'hF8); cs_high();
    cs_low(); dat(8'h00); dat(8'h1F); cs_high();
    tick(10);
    chk("cs_split_n_pix", obs_pix.size(), 1);
    if (obs_pix.size() > 0) chk("cs_split_pix", obs_pix[0], 16'h001F);
    compare_all("cs_split");

    // Five stray bits, CS bounce, then a clean command byte.
    cs_low();
    send_bits(8'hB5, 5, 1'b0);
    tick(4); cs = 1'b1; tick(6);
    cs_low(); cmd(8'h2A); cs_high();
    tick(10);
    if (obs_inst.size() > 0) chk("partial_inst", obs_inst[0], 16'h002A);
    compare_all("partial");

    // Reset between the two bytes of a pixel.
    cs_low(); cmd(8'h2C); dat(8'hF8);
    compare_all("pre_rst");
    rst = 1'b1;
    tick(2);
    chk_outputs_zero("mid_rst");
    rst = 1'b0;
    m_mode = 0; m_cnt = 0;
    tick(4);
    dat(8'h00);
    cmd(8'h29);
    cs_high();
    compare_all("post_rst");

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] c;
      int n;
      case ($urandom_range(0, 5))
        0: c = 8'h2A;
        1: c = 8'h2B;
        2, 3: c = 8'h2C;
        4: c = 8'h00;
        default: c = 8'($urandom_range(0, 255));
      endcase
      cs_low();
      cmd(c);
      n = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0) begin
          cs_high();
          cs_low();
        end
        dat(8'($urandom_range(0, 255)));
      end
      cs_high();
      compare_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/st7735_spi_rx.md
ST7735_SPI_RX -- requirements
Module: st7735_spi_rx

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer flops per SPI input; legal range 2..3.
REQ-002 Parameter: MAX_ROW, 271, highest row address accepted from RASET.
REQ-003 Port: mco  input  1  sole clock, all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_spi_clk  input  1  SPI clock, mode 0, asynchronous to mco.
REQ-006 Port: i_spi_cs  input  1  chip select, active-low, asynchronous.
REQ-007 Port: i_spi_mosi  input  1  serial data, MSB first.
REQ-008 Port: i_dc  input  1  data/command select, 1 = data, 0 = command.
REQ-009 Port: o_inst_data  output  8  last command byte received.
REQ-010 Port: o_inst_en_pls  output  1  one-cycle strobe, o_inst_data valid.
REQ-011 Port: o_pixel_data  output  16  RGB565 pixel, {first byte, second byte}.
REQ-012 Port: o_pixel_en_pls  output  1  one-cycle strobe, o_pixel_data valid.
REQ-013 Port: o_row_addr  output  16  RASET start row.
REQ-014 Port: o_row_addr_en_pls  output  1  one-cycle strobe, o_row_addr valid.

Function
REQ-015 i_spi_clk, i_spi_cs, i_spi_mosi and i_dc each pass through SYNC_STAGES flops before use.
REQ-016 One extra flop on synchronized SCK; rising edge detected as (sync=1, delayed=0).
REQ-017 On each detected rising edge with synchronized CS low: shift synchronized MOSI into an 8-bit register; increment a 3-bit bit counter.
REQ-018 Byte completes on the 8th edge; DC is sampled on that same edge; bit counter wraps to 0.
REQ-019 Synchronized CS high: clear bit counter, discard partial byte, drop held pixel high byte; the command state is kept.
REQ-020 Command byte (DC=0): o_inst_data updated and o_inst_en_pls high for exactly one cycle, the cycle after byte completion.
REQ-021 Decode FSM states: IDLE, CASET, RASET, RAMWR, SKIP; each command byte sets the state: 0x2A->CASET, 0x2B->RASET, 0x2C->RAMWR, 0x00->IDLE, any other->SKIP; the parameter byte index resets to 0.
REQ-022 CASET: the 4 data bytes are counted and discarded, then state->SKIP.
REQ-023 RASET: byte0 = start-row high, byte1 = start-row low; after byte1, o_row_addr = {byte0, byte1} clamped to MAX_ROW, and o_row_addr_en_pls pulses one cycle later; bytes 2-3 are discarded, then state->SKIP.
REQ-024 RAMWR: even-index data byte held; odd-index byte forms o_pixel_data = {held, byte} and o_pixel_en_pls pulses one cycle later; there is no byte limit and the index toggles modulo 2.
REQ-025 A trailing odd RAMWR byte is dropped on a new command byte or CS deassertion; no pixel strobe is produced for it.
REQ-026 Data bytes in IDLE or SKIP produce no strobe.
REQ-027 At most one strobe is high per cycle; all strobes are registered.
REQ-028 Data outputs hold their value until their next strobe.
REQ-029 Latency: strobe rises SYNC_STAGES+2 mco cycles after the 8th SCK rising edge at the pin.
REQ-030 Operating constraint: mco >= 4x SCK frequency, with SCK high and low phases each >= 2 mco periods; behaviour outside this constraint is undefined.

Reset
REQ-031 rst high: all synchronizer and edge flops cleared; i_spi_cs synchronizer flops preset to 1.
REQ-032 rst high: bit counter = 0, FSM = IDLE, byte index = 0.
REQ-033 rst high: all outputs = 0.
REQ-034 rst asserted mid-byte or mid-pixel discards the partial data and produces no strobe.

Structure
REQ-035 Shared package st7735_pkg holds the CMD_NOP/SWRESET/DISPOFF/DISPON/CASET/RASET/RAMWR constants and the decode state enum.
REQ-036 One sub-module, spi_bit_sync: a SYNC_STAGES-deep single-bit synchronizer, instantiated once per SPI input.

Verification
REQ-037 DC=0, byte 0x29 -> one o_inst_en_pls with o_inst_data = 0x29; no other strobe.
REQ-038 Command 0x2C, then data F8 00 07 E0 -> two pixel strobes, with values 0xF800 then 0x07E0.
REQ-039 Command 0x2B, then data 00 0A 01 0F -> one o_row_addr_en_pls with o_row_addr = 0x000A; 01 2C as start -> o_row_addr = 271.
REQ-040 Command 0x2C, data F8, CS high, CS low, data 00 1F -> exactly one pixel, 0x001F.
REQ-041 CS raised after 5 bits, then a full byte 0x2A is sent -> o_inst_data = 0x2A, with no corruption from the 5 discarded bits.
REQ-042 rst pulsed between the two bytes of a pixel -> no pixel strobe, all outputs 0, and the next command decodes normally.
